// File: rtl/multdiv_sched.sv
// multdiv_sched: execute-stage sequencer for the multi-cycle MULT/DIV/MADD/MSUB
// class. It owns the architectural HI/LO registers and contains a fixed-latency
// multiply pipe plus a radix-2 restoring divider with sign fix-up.
//
// Optional build macro: MULTDIV_DIV_EARLY_EXIT_EN
//   When defined, a divide whose dividend magnitude is below the divisor
//   magnitude (including a == 0) bypasses the iteration loop. The result is
//   lo = 0, hi = a, and done arrives two cycles after accept.
//
// Opcode encoding of req_op (decoded_op_t subset acted on here):
//   MULT=0x10 MULTU=0x11 DIV=0x12 DIVU=0x13 MADD=0x14 MADDU=0x15
//   MSUB=0x16 MSUBU=0x17 MTHI=0x18 MTLO=0x19. All other codes are accepted
//   and ignored.
module multdiv_sched #(
  parameter int MUL_LAT  = 3,   // accept-to-writeback cycles for the multiply family (1..8)
  parameter int DIV_ITER = 32   // restoring-divider iterations; 32 gives full word results
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [6:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [6:0] OP_MULT  = 7'h10;
  localparam logic [6:0] OP_MULTU = 7'h11;
  localparam logic [6:0] OP_DIV   = 7'h12;
  localparam logic [6:0] OP_DIVU  = 7'h13;
  localparam logic [6:0] OP_MADD  = 7'h14;
  localparam logic [6:0] OP_MADDU = 7'h15;
  localparam logic [6:0] OP_MSUB  = 7'h16;
  localparam logic [6:0] OP_MSUBU = 7'h17;
  localparam logic [6:0] OP_MTHI  = 7'h18;
  localparam logic [6:0] OP_MTLO  = 7'h19;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        done_reg;

  // Multiply pipe state
  logic [63:0] prod_reg;
  logic [1:0]  acc_mode_reg;

  // Divider state: dvd_reg shifts the dividend out and the quotient in
  logic [31:0] dvd_reg;
  logic [31:0] dvs_reg;
  logic [31:0] rem_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        div_zero_reg;
  logic        early_reg;

  // Request decode
  logic        accept;
  logic        op_is_mul;
  logic        op_is_div;
  logic        op_signed;
  logic [1:0]  acc_mode_in;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        q_neg_in;
  logic        r_neg_in;
  logic        early_exit;

  // Datapath results
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [31:0] rem_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [63:0] hilo_cur;
  logic [63:0] mul_result;

  assign req_ready = (state_reg == IDLE) & ~flush & ~reset;
  assign accept    = req_valid & req_ready;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign hi        = hi_reg;
  assign lo        = lo_reg;

  assign op_is_mul = (req_op == OP_MULT) | (req_op == OP_MULTU) |
                     (req_op == OP_MADD) | (req_op == OP_MADDU) |
                     (req_op == OP_MSUB) | (req_op == OP_MSUBU);
  assign op_is_div = (req_op == OP_DIV) | (req_op == OP_DIVU);
  assign op_signed = (req_op == OP_MULT) | (req_op == OP_MADD) |
                     (req_op == OP_MSUB) | (req_op == OP_DIV);

  // Accumulate mode selected by the multiply-family opcode
  always_comb begin
    acc_mode_in = ACC_NONE;
    if ((req_op == OP_MADD) || (req_op == OP_MADDU)) begin
      acc_mode_in = ACC_ADD;
    end else if ((req_op == OP_MSUB) || (req_op == OP_MSUBU)) begin
      acc_mode_in = ACC_SUB;
    end
  end

  // Sign- or zero-extend to 64 bits so a single 64x64 multiply truncated to
  // 64 bits gives the correct signed or unsigned full product.
  assign ext_a   = op_signed ? {{32{req_a[31]}}, req_a} : {32'd0, req_a};
  assign ext_b   = op_signed ? {{32{req_b[31]}}, req_b} : {32'd0, req_b};
  assign product = ext_a * ext_b;

  // Divider operand magnitudes; 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude.
  assign mag_a    = (op_signed & req_a[31]) ? (32'd0 - req_a) : req_a;
  assign mag_b    = (op_signed & req_b[31]) ? (32'd0 - req_b) : req_b;
  assign q_neg_in = op_signed & (req_a[31] ^ req_b[31]);
  assign r_neg_in = op_signed & req_a[31];

`ifdef MULTDIV_DIV_EARLY_EXIT_EN
  assign early_exit = (mag_a < mag_b);
`else
  assign early_exit = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor when it fits.
  assign div_shift = {rem_reg, dvd_reg[31]};
  assign div_ge    = (div_shift >= {1'b0, dvs_reg});
  assign div_sub   = div_shift[31:0] - dvs_reg;
  assign rem_next  = div_ge ? div_sub : div_shift[31:0];

  assign quot_fix = q_neg_reg ? (32'd0 - dvd_reg) : dvd_reg;
  assign rem_fix  = r_neg_reg ? (32'd0 - rem_reg) : rem_reg;

  // Multiply writeback value; accumulation reads HI/LO as they stand at writeback
  assign hilo_cur = {hi_reg, lo_reg};
  always_comb begin
    mul_result = prod_reg;
    case (acc_mode_reg)
      ACC_ADD: mul_result = hilo_cur + prod_reg;
      ACC_SUB: mul_result = hilo_cur - prod_reg;
      default: mul_result = prod_reg;
    endcase
  end

  // Sequencer FSM with HI/LO writeback and registered done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 6'd0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      done_reg     <= 1'b0;
      prod_reg     <= 64'd0;
      acc_mode_reg <= ACC_NONE;
      dvd_reg      <= 32'd0;
      dvs_reg      <= 32'd0;
      rem_reg      <= 32'd0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      early_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        // Killed op: drop any pending writeback and its done pulse
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              if (req_op == OP_MTHI) begin
                hi_reg <= req_a;
              end else if (req_op == OP_MTLO) begin
                lo_reg <= req_a;
              end else if (op_is_mul) begin
                state_reg    <= MUL;
                cnt_reg      <= 6'(MUL_LAT - 1);
                prod_reg     <= product;
                acc_mode_reg <= acc_mode_in;
              end else if (op_is_div) begin
                q_neg_reg <= q_neg_in;
                r_neg_reg <= r_neg_in;
                dvs_reg   <= mag_b;
                if (req_b == 32'd0) begin
                  // Divide by zero: one FIX cycle that only raises done
                  state_reg    <= FIX;
                  div_zero_reg <= 1'b1;
                  early_reg    <= 1'b0;
                end else if (early_exit) begin
                  // Quotient is zero and the remainder is the dividend; one
                  // pass through DIV without iterating, then FIX.
                  state_reg    <= DIV;
                  cnt_reg      <= 6'd0;
                  dvd_reg      <= 32'd0;
                  rem_reg      <= mag_a;
                  div_zero_reg <= 1'b0;
                  early_reg    <= 1'b1;
                end else begin
                  state_reg    <= DIV;
                  cnt_reg      <= 6'(DIV_ITER - 1);
                  dvd_reg      <= mag_a;
                  rem_reg      <= 32'd0;
                  div_zero_reg <= 1'b0;
                  early_reg    <= 1'b0;
                end
              end
            end
          end
          MUL: begin
            if (cnt_reg == 6'd0) begin
              hi_reg    <= mul_result[63:32];
              lo_reg    <= mul_result[31:0];
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg - 6'd1;
            end
          end
          DIV: begin
            if (!early_reg) begin
              rem_reg <= rem_next;
              dvd_reg <= {dvd_reg[30:0], div_ge};
            end
            if (cnt_reg == 6'd0) begin
              state_reg <= FIX;
            end else begin
              cnt_reg <= cnt_reg - 6'd1;
            end
          end
          FIX: begin
            if (!div_zero_reg) begin
              lo_reg <= quot_fix;
              hi_reg <= rem_fix;
            end
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
